// File: rtl/fnd_axil_pkg.sv
// Shared definitions for the FND counter AXI4-Lite slave: register indices,
// response codes, write-channel states and the hex-to-7-segment decoder.
package fnd_axil_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_VALUE   = 2'd1;
  localparam logic [1:0] REG_DP      = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;
  localparam int unsigned NUM_REGS   = int'(REG_SCRATCH) + 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {
    WR_COLLECT,
    WR_RESP
  } wr_state_e;

  // Active-low segments ordered {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fnd_scan_driver.sv
// Multiplexed 4-digit 7-segment driver: a prescaler steps the digit index and
// the selected nibble/decimal point are decoded into registered seg/an outputs.
module fnd_scan_driver
  import fnd_axil_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic [3:0]       nib;

  always_comb begin
    nib   = value[{idx_q, 2'b00} +: 4];
    seg_d = 8'hFF;
    an_d  = 4'hF;
    if (en) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = {~dp[idx_q], hex7seg(nib)};
    end
  end

  // The prescaler free-runs even while the display is blanked.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
      seg_q <= 8'hFF;
      an_q  <= 4'hF;
    end else begin
      if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
        cnt_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: rtl/fnd_axil_regslave.sv
// AXI4-Lite register slave for the FND counter IP: four 32-bit R/W registers
// with independent AW/W capture, single outstanding write and read, FND output.
module fnd_axil_regslave
  import fnd_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int SCAN_DIV           = 100000
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [7:0]                        seg,
  output logic [3:0]                        an
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = DW / 8;

  wr_state_e         wr_state_q, wr_state_d;
  logic              aw_held_q, w_held_q;
  logic [1:0]        aw_idx_q;
  logic [DW-1:0]     w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic              rvalid_q;
  logic [DW-1:0]     rdata_q;
  logic [DW-1:0]     regs_q [NUM_REGS];
  logic              aw_hs, w_hs, ar_hs, commit;
  logic              unused_inputs;

  assign S_AXI_AWREADY = (wr_state_q == WR_COLLECT) && !aw_held_q;
  assign S_AXI_WREADY  = (wr_state_q == WR_COLLECT) && !w_held_q;
  assign S_AXI_BVALID  = (wr_state_q == WR_RESP);
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = !rvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  always_comb begin
    wr_state_d = wr_state_q;
    commit     = 1'b0;
    case (wr_state_q)
      WR_COLLECT: begin
        if (aw_held_q && w_held_q) begin
          commit     = 1'b1;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (S_AXI_BREADY) wr_state_d = WR_COLLECT;
      end
      default: wr_state_d = WR_COLLECT;
    endcase
  end

  // Address and data are captured independently; commit releases both holds.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state_q <= WR_COLLECT;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= 2'd0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= S_AXI_AWADDR[3:2];
      end else if (commit) begin
        aw_held_q <= 1'b0;
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end else if (commit) begin
        w_held_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else if (commit) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_strb_q[b]) regs_q[aw_idx_q][8*b +: 8] <= w_data_q[8*b +: 8];
      end
    end
  end

  // Sampling uses the pre-commit register value when both land on one edge.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= regs_q[S_AXI_ARADDR[3:2]];
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  fnd_scan_driver #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .en     (regs_q[REG_CTRL][0]),
    .value  (regs_q[REG_VALUE][15:0]),
    .dp     (regs_q[REG_DP][3:0]),
    .seg    (seg),
    .an     (an)
  );

endmodule

// File: tb/tb_fnd_axil_regslave.sv
// Bench for fnd_axil_regslave: table-driven write/read-back vectors plus
// hand sequences for handshake timing, same-edge read/write, FND scan and reset.
module tb_fnd_axil_regslave;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [7:0]  seg;
  logic [3:0]  an;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  fnd_axil_regslave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (4),
    .SCAN_DIV           (4)
  ) dut (
    .ACLK          (clk),
    .ARESET        (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .seg           (seg),
    .an            (an)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];
  logic [3:0] exp_an  [4];
  logic [7:0] exp_seg [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      step(); n++;
      if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; wvalid  = 1'b0; end
    end
    if (!(aw_done && w_done)) chk("wr_accept_timeout", 32'(aw_done & w_done), 32'd1);
    n = 0;
    while (!bvalid && n < 50) begin step(); n++; end
    chk($sformatf("wr_bvalid@%h", a), 32'(bvalid), 32'd1);
    chk($sformatf("wr_bresp@%h", a), 32'(bresp), 32'd0);
    step();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp);
    logic hs;
    int n;
    exp_q.push_back(exp);
    araddr = a; arvalid = 1'b1; rready = 1'b1; n = 0; hs = 1'b0;
    while (!hs && n < 50) begin
      hs = arready;
      step(); n++;
    end
    arvalid = 1'b0;
    if (!hs) chk("rd_accept_timeout", 32'(hs), 32'd1);
    n = 0;
    while (!rvalid && n < 50) begin step(); n++; end
    chk($sformatf("rd_rvalid@%h", a), 32'(rvalid), 32'd1);
    chk($sformatf("rd_data@%h", a), rdata, exp_q.pop_front());
    chk($sformatf("rd_rresp@%h", a), 32'(rresp), 32'd0);
    step();
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] prev_an;
    int n;
    logic found;

    vecs[0] = '{4'h0, 32'h0000_0001, 4'hF, 32'h0000_0001};
    vecs[1] = '{4'h4, 32'h0000_0002, 4'hF, 32'h0000_0002};
    vecs[2] = '{4'h8, 32'h0000_0003, 4'hF, 32'h0000_0003};
    vecs[3] = '{4'hC, 32'h0000_0004, 4'hF, 32'h0000_0004};
    vecs[4] = '{4'h4, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF};
    vecs[5] = '{4'h4, 32'h1234_5678, 4'h5, 32'hFF34_FF78};
    vecs[6] = '{4'hF, 32'hA5A5_5A5A, 4'hF, 32'hA5A5_5A5A};
    vecs[7] = '{4'hC, 32'h0000_0000, 4'h0, 32'hA5A5_5A5A};
    exp_an[0] = 4'hE;  exp_seg[0] = 8'h40;
    exp_an[1] = 4'hD;  exp_seg[1] = 8'hF9;
    exp_an[2] = 4'hB;  exp_seg[2] = 8'hA4;
    exp_an[3] = 4'h7;  exp_seg[3] = 8'hB0;

    rst = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = '0; wstrb = '0;
    repeat (3) step();
    rst = 1'b0;

    chk("rst_readies", 32'({awready, wready, arready}), 32'h7);
    chk("rst_valids", 32'({bvalid, rvalid}), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_an", 32'(an), 32'hF);

    for (int i = 0; i < 8; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      axi_read(vecs[i].addr, vecs[i].exp);
    end
    axi_read(4'h1, 32'h0000_0001);
    axi_read(4'h8, 32'h0000_0003);

    // AW leads W by three cycles; BREADY withheld for five cycles.
    awaddr = 4'hC; awvalid = 1'b1; bready = 1'b0;
    step();
    awvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("aw_lead_awready", 32'(awready), 32'd0);
      chk("aw_lead_wready_bvalid", 32'({wready, bvalid}), 32'b10);
      if (c < 2) step();
    end
    wdata = 32'hC0DE_0002; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("w_accept_bvalid_not_yet", 32'(bvalid), 32'd0);
    step();
    chk("w_accept_bvalid_next", 32'(bvalid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bhold_bvalid", 32'(bvalid), 32'd1);
      chk("bhold_readies", 32'({awready, wready}), 32'd0);
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("after_b_bvalid", 32'(bvalid), 32'd0);
    chk("after_b_readies", 32'({awready, wready}), 32'h3);
    axi_read(4'hC, 32'hC0DE_0002);

    // Read sampled on the same edge as a commit to the same register.
    awaddr = 4'hC; wdata = 32'hBEEF_0003; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    exp_q.push_back(32'hC0DE_0002);
    araddr = 4'hC; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    chk("same_edge_bvalid", 32'(bvalid), 32'd1);
    chk("same_edge_rvalid", 32'(rvalid), 32'd1);
    chk("same_edge_rdata_old", rdata, exp_q.pop_front());
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    axi_read(4'hC, 32'hBEEF_0003);

    // Scan pattern: each digit dwells exactly four cycles.
    axi_write(4'h4, 32'h0000_3210, 4'hF);
    axi_write(4'h8, 32'h0000_0001, 4'hF);
    axi_write(4'h0, 32'h0000_0001, 4'hF);
    prev_an = an; found = 1'b0; n = 0;
    while (!found && n < 100) begin
      step(); n++;
      if (an == 4'hB && prev_an == 4'hD) found = 1'b1;
      prev_an = an;
    end
    chk("scan_sync", 32'(found), 32'd1);
    for (int k = 2; k < 7; k++) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("scan_an_d%0d", k % 4), 32'(an), 32'(exp_an[k % 4]));
        chk($sformatf("scan_seg_d%0d", k % 4), 32'(seg), 32'(exp_seg[k % 4]));
        step();
      end
    end

    // Blank while scanning, then resume.
    axi_write(4'h0, 32'h0000_0000, 4'hF);
    for (int c = 0; c < 6; c++) begin
      chk("blank_an", 32'(an), 32'hF);
      chk("blank_seg", 32'(seg), 32'hFF);
      step();
    end
    axi_write(4'h0, 32'h0000_0001, 4'hF);
    n = 0;
    while (an == 4'hF && n < 10) begin step(); n++; end
    chk("resume_an_onehot",
        32'((an == 4'hE) || (an == 4'hD) || (an == 4'hB) || (an == 4'h7)), 32'd1);

    // Reset with both a B and an R response pending.
    awaddr = 4'h4; wdata = 32'h0000_0055; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 4'h0; arvalid = 1'b1; rready = 1'b0;
    step();
    arvalid = 1'b0;
    chk("pre_rst_pending", 32'({bvalid, rvalid}), 32'h3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_readies", 32'({awready, wready, arready}), 32'h7);
    chk("mid_rst_valids", 32'({bvalid, rvalid}), 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    bready = 1'b1; rready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("mid_rst_no_resp", 32'({bvalid, rvalid}), 32'h0);
    end
    bready = 1'b0; rready = 1'b0;
    chk("mid_rst_seg_an", 32'({seg, an}), 32'hFFF);
    for (int r = 0; r < 4; r++) axi_read(4'(r * 4), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
